// File: rtl/vga_pkg.sv
// Shared definitions for the VGA/host video RAM arbiter: default widths,
// pipeline tag encoding and the arbitration grant type.
package vga_pkg;

    localparam int ADDR_W_DEF        = 13;
    localparam int DATA_W_DEF        = 8;
    localparam int HOST_MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_SKID,
        GNT_DISP,
        GNT_HOST
    } grant_t;

endpackage

// File: rtl/vga_skid1.sv
// One-entry display address buffer: holds a fetch deferred by a forced host
// grant until it can be issued on the following cycle.
module vga_skid1
    import vga_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              load,
    input  logic              pop,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              occupied,
    output logic [ADDR_W-1:0] addr,
    output logic              overflow
);

    // A load against a full entry is dropped; the caller records it as overrun.
    assign overflow = load & occupied;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            occupied <= 1'b0;
            addr     <= '0;
        end else if (load && !occupied) begin
            occupied <= 1'b1;
            addr     <= load_addr;
        end else if (pop) begin
            occupied <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has priority, the host port is
// forced through after HOST_MAX_WAIT lost cycles, results return after 2 cycles.
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_overrun,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(HOST_MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);

    grant_t            grant;
    tag_t              tag1, tag2;
    logic              host_busy;
    logic [WAIT_W-1:0] wait_cnt;
    logic              host_elig, forced;
    logic              skid_load, skid_occ, skid_overflow;
    logic [ADDR_W-1:0] skid_addr;

    assign host_elig = host_req & ~host_busy;
    assign forced    = host_elig & ~skid_occ & (wait_cnt == WAIT_MAX);

    always_comb begin
        grant = GNT_NONE;
        if (skid_occ)
            grant = GNT_SKID;
        else if (forced)
            grant = GNT_HOST;
        else if (disp_req)
            grant = GNT_DISP;
        else if (host_elig)
            grant = GNT_HOST;
    end

    // Any fetch that cannot issue now is offered to the skid; if it is
    // already holding an entry the offer overflows and the fetch is lost.
    assign skid_load = disp_req & (skid_occ | forced);

    vga_skid1 #(
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk50    (clk50),
        .reset    (reset),
        .load     (skid_load),
        .pop      (grant == GNT_SKID),
        .load_addr(disp_addr),
        .occupied (skid_occ),
        .addr     (skid_addr),
        .overflow (skid_overflow)
    );

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            tag1         <= TAG_NONE;
            tag2         <= TAG_NONE;
            host_busy    <= 1'b0;
            wait_cnt     <= '0;
            disp_overrun <= 1'b0;
        end else begin
            unique case (grant)
                GNT_SKID: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= skid_addr;
                    tag1     <= TAG_DISP;
                end
                GNT_DISP: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= disp_addr;
                    tag1     <= TAG_DISP;
                end
                GNT_HOST: begin
                    mem_en   <= 1'b1;
                    mem_we   <= host_we;
                    mem_addr <= host_addr;
                    if (host_we)
                        mem_wdata <= host_wdata;
                    tag1     <= TAG_HOST;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    tag1   <= TAG_NONE;
                end
            endcase
            tag2 <= tag1;

            if (grant == GNT_HOST)
                host_busy <= 1'b1;
            else if (tag2 == TAG_HOST)
                host_busy <= 1'b0;

            if (!host_req || grant == GNT_HOST)
                wait_cnt <= '0;
            else if (host_elig && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            if (skid_overflow)
                disp_overrun <= 1'b1;
        end
    end

    assign disp_valid = (tag2 == TAG_DISP);
    assign host_ack   = (tag2 == TAG_HOST);
    assign disp_data  = disp_valid ? mem_rdata : '0;
    assign host_rdata = host_ack   ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter: a transaction-level model predicts
// every cycle's outputs, backed by hand-computed literal checks per scenario.
module tb_vga_vram_arbiter;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int MAXW = 15;

    logic          clk50 = 1'b0;
    logic          reset;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          disp_overrun;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #10 clk50 = ~clk50;

    vga_vram_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .HOST_MAX_WAIT(MAXW)
    ) dut (
        .clk50(clk50), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
        .disp_data(disp_data), .disp_overrun(disp_overrun),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM with one cycle of read latency
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk50) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int dv_count = 0, ack_count = 0, en_count = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (period %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        bit          en;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit          dv;
        logic [DW-1:0] ddata;
        bit          ack;
        bit          rd;
        logic [DW-1:0] rdata;
    } slot_t;

    slot_t         slots [4];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [AW-1:0] skid_q [$];
    int unsigned   waits = 0;
    int unsigned   host_free_at = 0;
    bit            m_overrun = 1'b0;

    task automatic serve_disp(input int unsigned n1, input int unsigned n2, input logic [AW-1:0] a);
        slots[n1].en    = 1'b1;
        slots[n1].we    = 1'b0;
        slots[n1].addr  = a;
        slots[n2].dv    = 1'b1;
        slots[n2].ddata = shadow[a];
    endtask

    always @(posedge clk50 or posedge reset) begin
        int unsigned k, n1, n2;
        bit elig, forced, host_won;
        if (reset) begin
            for (int i = 0; i < 4; i++) slots[i] = '{default: '0};
            skid_q.delete();
            waits = 0;
            host_free_at = 0;
            m_overrun = 1'b0;
        end else begin
            k  = cyc;
            n1 = (k + 1) % 4;
            n2 = (k + 2) % 4;
            slots[n1].en = 1'b0; slots[n1].we = 1'b0;
            slots[n2].dv = 1'b0; slots[n2].ack = 1'b0; slots[n2].rd = 1'b0;
            // host may start a new access 3 periods after its previous grant
            elig     = host_req && (k >= host_free_at);
            forced   = elig && (waits == MAXW) && (skid_q.size() == 0);
            host_won = 1'b0;
            if (skid_q.size() != 0) begin
                serve_disp(n1, n2, skid_q.pop_front());
                if (disp_req) m_overrun = 1'b1;
            end else if (forced) begin
                host_won = 1'b1;
                if (disp_req) skid_q.push_back(disp_addr);
            end else if (disp_req) begin
                serve_disp(n1, n2, disp_addr);
            end else if (elig) begin
                host_won = 1'b1;
            end
            if (host_won) begin
                slots[n1].en    = 1'b1;
                slots[n1].we    = host_we;
                slots[n1].addr  = host_addr;
                slots[n1].wdata = host_wdata;
                slots[n2].ack   = 1'b1;
                slots[n2].rd    = !host_we;
                slots[n2].rdata = shadow[host_addr];
                if (host_we) shadow[host_addr] = host_wdata;
                host_free_at = k + 3;
            end
            if (!host_req || host_won) waits = 0;
            else if (elig && waits < MAXW) waits++;
            cyc++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk50) begin
        slot_t s;
        s = slots[cyc % 4];
        chk("mem_en", mem_en, s.en);
        chk("mem_we", mem_we, s.we);
        if (s.en) chk("mem_addr", mem_addr, s.addr);
        if (s.en && s.we) chk("mem_wdata", mem_wdata, s.wdata);
        chk("disp_valid", disp_valid, s.dv);
        if (s.dv) chk("disp_data", disp_data, s.ddata);
        chk("host_ack", host_ack, s.ack);
        if (s.rd) chk("host_rdata", host_rdata, s.rdata);
        chk("disp_overrun", disp_overrun, m_overrun);
        chk("valid_ack_exclusive", disp_valid & host_ack, 0);
        if (reset) begin
            chk("rst_disp_data", disp_data, 0);
            chk("rst_host_rdata", host_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end
        if (disp_valid === 1'b1) dv_count++;
        if (host_ack === 1'b1) ack_count++;
        if (mem_en === 1'b1) en_count++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic host_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             output logic [DW-1:0] rd, output int lat);
        int unsigned p;
        bit done;
        p = cyc;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
        done = 1'b0;
        rd = '0;
        lat = -1;
        for (int t = 0; t < 40 && !done; t++) begin
            tick();
            if (host_ack === 1'b1) begin
                rd = host_rdata;
                lat = int'(cyc - p);
                done = 1'b1;
            end
        end
        host_req = 1'b0;
        if (!done) chk("host_xfer_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int lat, dv0, ack0, en0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = 8'(i) ^ 8'h3C;
            shadow[i] = 8'(i) ^ 8'h3C;
        end
        ram[16] = 8'hA5;
        shadow[16] = 8'hA5;

        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) tick();
        chk("reset_mem_en", mem_en, 0);
        chk("reset_overrun", disp_overrun, 0);
        reset = 1'b0;
        repeat (2) tick();

        // Host read of 0x0010, request held past ack to observe re-grant spacing
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0010;
        tick();
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 13'h0010);
        tick();
        chk("t1_ack", host_ack, 1);
        chk("t1_rdata", host_rdata, 8'hA5);
        tick();
        chk("t1_no_grant_after_ack", mem_en, 0);
        tick();
        chk("t1_regrant", mem_en, 1);
        tick();
        chk("t1_ack2", host_ack, 1);
        host_req = 1'b0;
        repeat (3) tick();

        // Contention: display every period (one gap after the forced grant), host write pending
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h1234; host_wdata = 8'h5A;
        for (int p = 0; p < 42; p++) begin
            if (p == 16 || p > 40) disp_req = 1'b0;
            else begin
                disp_req = 1'b1;
                disp_addr = AW'(p < 16 ? p : p - 1);
            end
            if (p >= 1 && p <= 15) begin
                chk("cont_disp_wins_we", mem_we, 0);
                chk("cont_disp_wins_addr", mem_addr, 13'(p - 1));
            end
            if (p == 16) begin
                chk("cont_forced_en", mem_en, 1);
                chk("cont_forced_we", mem_we, 1);
                chk("cont_forced_addr", mem_addr, 13'h1234);
                chk("cont_forced_wdata", mem_wdata, 8'h5A);
            end
            if (p == 17) begin
                chk("cont_skid_addr", mem_addr, 13'd15);
                chk("cont_host_ack", host_ack, 1);
                host_req = 1'b0;
            end
            if (p == 18) begin
                chk("cont_skid_valid", disp_valid, 1);
                chk("cont_skid_data", disp_data, 8'h33);
            end
            tick();
        end
        chk("cont_no_overrun", disp_overrun, 0);
        host_xfer(1'b0, 13'h1234, 8'h00, rd, lat);
        chk("cont_readback", rd, 8'h5A);
        chk("cont_read_latency", lat, 2);
        repeat (2) tick();

        // Idle
        dv0 = dv_count; ack0 = ack_count; en0 = en_count;
        repeat (100) tick();
        chk("idle_mem_en_cycles", en_count - en0, 0);
        chk("idle_valids", dv_count - dv0, 0);
        chk("idle_acks", ack_count - ack0, 0);

        // 640 back-to-back display fetches
        dv0 = dv_count; ack0 = ack_count;
        for (int p = 0; p < 640; p++) begin
            disp_req = 1'b1;
            disp_addr = AW'(p);
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();
        chk("line_valids", dv_count - dv0, 640);
        chk("line_acks", ack_count - ack0, 0);

        // Overrun: skid filled by forced grant, next fetch arrives while it drains
        dv0 = dv_count;
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0100; host_wdata = 8'h77;
        for (int p = 0; p < 20; p++) begin
            disp_req = 1'b1;
            disp_addr = AW'(100 + p);
            if (p == 16) chk("ovr_before", disp_overrun, 0);
            if (p == 17) begin
                chk("ovr_set", disp_overrun, 1);
                chk("ovr_host_ack", host_ack, 1);
                host_req = 1'b0;
            end
            tick();
        end
        host_req = 1'b0;
        disp_req = 1'b0;
        repeat (4) tick();
        chk("ovr_valids", dv_count - dv0, 19);
        repeat (20) tick();
        chk("ovr_sticky", disp_overrun, 1);

        // Asynchronous reset one period after a host grant
        ack0 = ack_count;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0020;
        tick();
        chk("rst_grant_seen", mem_en, 1);
        #4 reset = 1'b1;
        #1;
        chk("rst_now_mem_en", mem_en, 0);
        chk("rst_now_mem_we", mem_we, 0);
        chk("rst_now_mem_addr", mem_addr, 0);
        chk("rst_now_host_ack", host_ack, 0);
        chk("rst_now_disp_valid", disp_valid, 0);
        chk("rst_now_overrun", disp_overrun, 0);
        host_req = 1'b0;
        repeat (2) @(posedge clk50);
        #7 reset = 1'b0;
        repeat (6) tick();
        chk("rst_no_ack", ack_count - ack0, 0);

        // Wait counter starts from zero after reset: forced exactly on the 16th period
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h1FFF;
        for (int p = 0; p < 20; p++) begin
            disp_req = 1'b1;
            disp_addr = AW'(p);
            if (p == 15) chk("rst_wait_disp14", mem_addr, 13'd14);
            if (p == 16) begin
                chk("rst_wait_forced_addr", mem_addr, 13'h1FFF);
                chk("rst_wait_forced_we", mem_we, 0);
            end
            if (p == 17) begin
                chk("rst_wait_ack", host_ack, 1);
                chk("rst_wait_rdata", host_rdata, 8'hC3);
                host_req = 1'b0;
            end
            tick();
        end
        host_req = 1'b0;
        disp_req = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
Shares one synchronous single-port video RAM between two requesters. The first is the VGA scan-out fetch, which is latency-critical and has no backpressure. The second is a host read/write port with a req/ack handshake. The block sits between the VGA timing/pixel pipeline and the frame-buffer RAM, all in the clk50 domain. Display fetch has priority; a one-entry display skid buffer and a wait counter guarantee host forward progress.

Parameters:
ADDR_W, 13, frame-buffer word address width
DATA_W, 8, RAM word width
HOST_MAX_WAIT, 15, cycles a pending host request may lose arbitration before it is forced through

Ports:
clk50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
disp_req  in  1  one-cycle fetch strobe from the scan-out pipeline
disp_addr  in  ADDR_W  fetch address, valid with disp_req
disp_valid  out  1  one-cycle pulse; disp_data valid
disp_data  out  DATA_W  fetched word
disp_overrun  out  1  sticky: a display request was dropped
host_req  in  1  level; held with addr/we/wdata until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  read data, valid with host_ack (undefined for writes)
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_en

Behaviour:
- Reset: every output is 0. Skid buffer empty, wait counter 0, host_busy 0, pipeline tags cleared. Reset asserted mid-transaction aborts it silently: no ack or valid is issued for it.
- Pipeline:
  - Cycle N: arbitration over the request sources.
  - Cycle N+1: registered mem_* outputs drive the winner and a tag (DISP/HOST/NONE) enters stage 1.
  - Cycle N+2: the stage-2 tag routes mem_rdata. DISP pulses disp_valid with disp_data. HOST pulses host_ack with host_rdata.
  - Normal latency for both ports is 2 cycles from request. A skid-delayed display fetch takes 3.
- Request sources, highest priority first:
  1. Skid buffer occupied.
  2. Live disp_req.
  3. Host eligible: host_req=1 and host_busy=0.
- Default grant:
  - Skid occupied: skid is served. A simultaneous disp_req is lost, and disp_overrun is set.
  - Skid empty, disp_req=1: display is served.
  - Otherwise, host eligible: host is served.
- Forced host (wait counter == HOST_MAX_WAIT, host eligible, skid empty):
  - The host is granted.
  - A simultaneous disp_req goes into the skid and is served next cycle.
- Wait counter:
  - Increments each cycle the host is eligible and not granted; saturates at HOST_MAX_WAIT.
  - Clears on host grant or when host_req=0.
- host_busy:
  - Set on host grant; cleared in the cycle host_ack pulses.
  - A host request held high after ack is a new transaction, re-eligible the following cycle. Maximum host throughput is one access per 3 cycles.
- Writes: mem_we=1 with mem_wdata=host_wdata in the grant cycle. Ack follows at N+2, with the same timing as reads.
- Display never writes: mem_we=0 for DISP grants.
- Idle cycle: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their previous values.
- disp_overrun is cleared only by reset.
- Invariant: at most one of disp_valid and host_ack per cycle.

Decomposition:
- Shared package vga_pkg:
  - ADDR_W/DATA_W defaults.
  - Tag encoding: TAG_NONE=2'd0, TAG_DISP=2'd1, TAG_HOST=2'd2.
  - Grant enum.
- One natural sub-module, vga_skid1: one-entry address register with occupied flag and load/pop/overflow signals.
- Arbitration, counter and tag pipeline stay in the top level.

Test Plan:
- Host only, read:
  - Stimulus: reset release, then host read of addr 0x0010, with the RAM model holding 0xA5 there.
  - Required: mem_en=1, mem_we=0 one cycle after req; host_ack=1 with host_rdata=0xA5 two cycles after req; next grant no earlier than the cycle after ack.
- Contention:
  - Stimulus: disp_req every cycle at addresses 0..39; host write 0x1234 <- 0x5A pending throughout.
  - Required:
    - Display wins 15 cycles; host is forced on cycle 16.
    - That cycle's disp_req enters the skid and gets disp_valid at latency 3.
    - No overrun. A later host read of 0x1234 returns 0x5A.
- Overrun:
  - Stimulus: force the skid full, then disp_req on the next cycle while the skid is draining.
  - Required: one request lost; disp_overrun=1 and it stays 1 until reset.
- Display ordering:
  - Stimulus: 640 back-to-back disp_req at incrementing addresses, no host traffic.
  - Required: 640 disp_valid pulses, in order, each exactly 2 cycles after its request; zero host_ack.
- Async reset mid-access:
  - Stimulus: assert reset one cycle after a host grant, asynchronously to clk50.
  - Required: all outputs go to 0 immediately; no host_ack after release; wait counter starts at 0.
- Idle:
  - Stimulus: no requests for 100 cycles.
  - Required: mem_en=0, mem_we=0 throughout; no valid or ack pulses.
